store_buffer: RTL and testbench
===============================

# store_buffer

Store-side counterpart of the immediate/load extenders: takes 32-bit store requests from the MEM stage, narrows them into byte-lane-aligned write data plus byte enables, queues them in a small FIFO, and drains them to the data memory/bridge over a valid/ready handshake. It also detects misaligned stores and raises an AdES exception instead of writing. It sits between the MEM-stage pipeline register and the DM/bridge write port.

## Interface
- DEPTH, 2, FIFO entries; a power of two, at least 2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  MEM stage presents a store
- req_ready  out  1  buffer can accept; equals !full
- req_addr  in  32  byte address
- req_data  in  32  unaligned source data; the low byte or half is used for sb/sh
- req_op  in  2  `st_word`=00, `st_half`=01, `st_byte`=10, 11 reserved
- exc_ades  out  1  one-cycle pulse; misaligned store was rejected
- exc_addr  out  32  offending byte address; holds until the next exception
- mem_valid  out  1  head entry is valid; equals !empty
- mem_ready  in  1  memory consumes the head this cycle
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated data
- mem_be  out  4  byte enables; bit i covers bits [8i+7:8i]
- empty  out  1  no pending stores; the hazard unit stalls loads until this is 1

## Operation
- A push occurs when req_valid && req_ready. A pop occurs when mem_valid && mem_ready.
- Lane formatting, with a = req_addr[1:0]:
  - sw: be=4'b1111, wdata=data.
  - sh: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{data[15:0]}}.
  - sb: be=4'b0001<<a, wdata={4{data[7:0]}}.
- Misaligned requests: sh with a[0]=1, or sw with a!=0.
  - The request is accepted (consumed) but not enqueued.
  - exc_ades pulses on the next cycle and exc_addr latches req_addr.
- A reserved op (11) is accepted and dropped silently, with no exception.
- The FIFO uses rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
  - full = count==DEPTH; empty = count==0.
- Simultaneous push and pop: both take effect, count is unchanged, and both pointers advance.
- Pushing while full is impossible because req_ready is low; upstream must stall. There is no same-cycle bypass when full, even if a pop occurs.
- Popping while empty is impossible because mem_valid is low; mem_ready is ignored.
- Entries drain strictly in FIFO order.

## Timing
- Reset values:
  - req_ready=1, mem_valid=0, empty=1.
  - mem_addr=0, mem_wdata=0, mem_be=0.
  - exc_ades=0, exc_addr=0.
  - Pointers and count are 0.
- Push-to-mem_valid latency is 1 cycle. The mem_* outputs are driven combinationally from the registered head entry.
- When mem_valid=0, mem_be is forced to 0. mem_addr and mem_wdata may show stale entry contents.
- While mem_valid=1 and mem_ready=0, the mem_* outputs hold stable.
- req_ready and empty are combinational from count only; there is no path from req_valid to req_ready.
- exc_ades is registered and asserts exactly 1 cycle after the offending push.
- Reset mid-operation discards all pending entries and any exception pulse in flight. Outputs reach their reset values asynchronously.

## Structure
- The st_op codes (`st_word`, `st_half`, `st_byte`) live in the shared header, head.v, alongside the existing extender op codes.
- Sub-module store_lane (combinational): takes addr[1:0], op, and data, and produces be, wdata, misaligned, and reserved. Instantiated once on the request side; entries store the already-formatted values.
- Top level: FIFO storage arrays (addr[31:2], wdata, be), pointer/count logic, and the exception register.

## Test plan
- Reset, then sb addr=0x1003, data=0x000000A5, with mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5. Then empty=1.
- sh addr=0x2002, data=0x1234BEEF -> be=1100, wdata=0xBEEFBEEF. sw addr=0x2004, data=0xCAFEF00D -> be=1111.
- sh addr=0x3001 -> no enqueue, exc_ades pulses 1 cycle later, exc_addr=0x3001, empty stays 1. Same check for sw addr=0x3002.
- With mem_ready=0, push 2 stores -> req_ready=0 and mem_* hold the first entry. Raise mem_ready -> drains in order, with req_ready=1 after the first pop.
- Steady state: push and pop every cycle for 8 cycles with count=1 -> count stays 1, pointers wrap, data order is preserved.
- Assert reset while 2 entries are pending and an exc_ades is in flight -> immediately mem_valid=0, empty=1, exc_ades=0, with no writes afterwards.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared store op codes and FIFO entry type for the store buffer
package store_buffer_pkg;

    // Store op codes carried from the MEM stage
    typedef enum logic [1:0] {
        ST_WORD = 2'b00,
        ST_HALF = 2'b01,
        ST_BYTE = 2'b10,
        ST_RSVD = 2'b11
    } st_op_t;

    // One queued store, already lane-formatted; the address is kept word-granular
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_lane.sv
// rtl/store_buffer_lane.sv - narrows a store into byte enables and lane-replicated write data
module store_buffer_lane
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  op,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        reserved
);

    // Replicate the source byte/half across all lanes so the memory only needs the enables
    always_comb begin
        be         = 4'b0000;
        wdata      = data;
        misaligned = 1'b0;
        reserved   = 1'b0;
        case (op)
            ST_WORD: begin
                be         = 4'b1111;
                wdata      = data;
                misaligned = (addr_lo != 2'b00);
            end
            ST_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{data[15:0]}};
                misaligned = addr_lo[0];
            end
            ST_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            default: begin
                reserved = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between the MEM stage and the data memory write port
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_op,
    output logic        exc_ades,
    output logic [31:0] exc_addr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    sb_entry_t      fifo [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;

    logic [3:0]     lane_be;
    logic [31:0]    lane_wdata;
    logic           lane_misaligned;
    logic           lane_reserved;

    logic           full;
    logic           push;
    logic           enq;
    logic           pop;
    sb_entry_t      head;

    store_buffer_lane u_store_lane (
        .addr_lo    (req_addr[1:0]),
        .op         (req_op),
        .data       (req_data),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .misaligned (lane_misaligned),
        .reserved   (lane_reserved)
    );

    // Handshake decode: readiness depends on count only, never on req_valid
    always_comb begin
        full      = (count == CNT_FULL);
        empty     = (count == '0);
        req_ready = !full;
        mem_valid = !empty;
        push      = req_valid && req_ready;
        enq       = push && !lane_misaligned && !lane_reserved;
        pop       = mem_valid && mem_ready;
    end

    // Head entry drives the memory port; enables are gated so an idle port never writes
    always_comb begin
        head      = fifo[rd_ptr];
        mem_addr  = {head.addr, 2'b00};
        mem_wdata = head.wdata;
        mem_be    = mem_valid ? head.be : 4'b0000;
    end

    // Entry storage: write the formatted request into the tail slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else if (enq) begin
            fifo[wr_ptr] <= '{addr: req_addr[31:2], wdata: lane_wdata, be: lane_be};
        end
    end

    // Pointer and occupancy tracking; concurrent push and pop leave count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Misaligned-store exception: one-cycle pulse, address held until the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_ades <= 1'b0;
            exc_addr <= '0;
        end else begin
            exc_ades <= push && lane_misaligned;
            if (push && lane_misaligned) begin
                exc_addr <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_op = '0;
    logic        exc_ades;
    logic [31:0] exc_addr;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;

    store_buffer #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_op    (req_op),
        .exc_ades  (exc_ades),
        .exc_addr  (exc_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
        logic        enq;
        logic        exc;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    localparam int NV = 13;
    vec_t        vt [NV];
    exp_t        sb_q [$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_exc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write the memory accepts must match the oldest expected store
    always @(negedge clk) begin
        if (!reset && mem_valid && mem_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%h be=%b want none at %0t", mem_addr, mem_be, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("wr_addr", mem_addr, mon_e.addr);
                check("wr_wdata", mem_wdata, mon_e.wdata);
                check("wr_be", {28'd0, mem_be}, {28'd0, mon_e.be});
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, then check the exception response
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] o,
                        input logic enq, input logic exc,
                        input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_op    = o;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got req_ready=0 want 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        if (enq) sb_q.push_back('{ea, ew, eb});
        @(posedge clk); #1;
        check("exc_ades", {31'd0, exc_ades}, {31'd0, exc});
        if (exc) check("exc_addr", exc_addr, a);
    endtask

    initial begin
        vt[0]  = '{32'h0000_1003, 32'h0000_00A5, ST_BYTE, 1'b1, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
        vt[1]  = '{32'h0000_2002, 32'h1234_BEEF, ST_HALF, 1'b1, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
        vt[2]  = '{32'h0000_2004, 32'hCAFE_F00D, ST_WORD, 1'b1, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111};
        vt[3]  = '{32'h0000_0000, 32'h1234_5678, ST_BYTE, 1'b1, 1'b0, 32'h0000_0000, 32'h7878_7878, 4'b0001};
        vt[4]  = '{32'h0000_0005, 32'hFF00_AA11, ST_BYTE, 1'b1, 1'b0, 32'h0000_0004, 32'h1111_1111, 4'b0010};
        vt[5]  = '{32'h0000_0006, 32'h0000_003C, ST_BYTE, 1'b1, 1'b0, 32'h0000_0004, 32'h3C3C_3C3C, 4'b0100};
        vt[6]  = '{32'h0000_0010, 32'hFFFF_8001, ST_HALF, 1'b1, 1'b0, 32'h0000_0010, 32'h8001_8001, 4'b0011};
        vt[7]  = '{32'h0000_3001, 32'h1111_2222, ST_HALF, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vt[8]  = '{32'h0000_3002, 32'h3333_4444, ST_WORD, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vt[9]  = '{32'h0000_3003, 32'h5555_6666, ST_WORD, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vt[10] = '{32'h0000_4001, 32'h7777_8888, ST_RSVD, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000};
        vt[11] = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, ST_WORD, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 4'b1111};
        vt[12] = '{32'h0000_0007, 32'h0000_9999, ST_HALF, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_exc_ades", {31'd0, exc_ades}, 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_exc = 32'd0;

        // Table-driven single stores with the memory always ready
        mem_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            send(vt[i].addr, vt[i].data, vt[i].op, vt[i].enq, vt[i].exc,
                 vt[i].e_addr, vt[i].e_wdata, vt[i].e_be);
            req_valid = 1'b0;
            if (vt[i].exc) last_exc = vt[i].addr;
            check("vec_mem_valid", {31'd0, mem_valid}, {31'd0, vt[i].enq});
            if (vt[i].enq) check("vec_mem_be", {28'd0, mem_be}, {28'd0, vt[i].e_be});
            @(posedge clk); #1;
            check("vec_empty", {31'd0, empty}, 32'd1);
            check("vec_exc_clear", {31'd0, exc_ades}, 32'd0);
            check("vec_exc_hold", exc_addr, last_exc);
        end

        // Backpressure: two stores fill the buffer and the head holds steady
        mem_ready = 1'b0;
        send(32'h0000_5000, 32'h1111_1111, ST_WORD, 1'b1, 1'b0, 32'h0000_5000, 32'h1111_1111, 4'b1111);
        send(32'h0000_5006, 32'h0000_2222, ST_HALF, 1'b1, 1'b0, 32'h0000_5004, 32'h2222_2222, 4'b1100);
        req_valid = 1'b0;
        check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        check("bp_head_addr", mem_addr, 32'h0000_5000);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_addr", mem_addr, 32'h0000_5000);
        check("bp_hold_wdata", mem_wdata, 32'h1111_1111);
        check("bp_hold_be", {28'd0, mem_be}, 32'hF);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_pop", {31'd0, req_ready}, 32'd1);
        check("bp_second_addr", mem_addr, 32'h0000_5004);
        @(posedge clk); #1;
        check("bp_drained", {31'd0, empty}, 32'd1);

        // Steady state: push and pop every cycle with one entry resident
        for (int k = 0; k < 9; k++) begin
            send(32'h0000_6000 + 32'(k * 4), 32'h0101_0101 * 32'(k + 1), ST_WORD, 1'b1, 1'b0,
                 32'h0000_6000 + 32'(k * 4), 32'h0101_0101 * 32'(k + 1), 4'b1111);
            check("ss_req_ready", {31'd0, req_ready}, 32'd1);
            check("ss_not_empty", {31'd0, empty}, 32'd0);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("ss_drained", {31'd0, empty}, 32'd1);

        // Reset with an entry pending and an exception pulse in flight
        mem_ready = 1'b0;
        send(32'h0000_7000, 32'hAAAA_AAAA, ST_WORD, 1'b1, 1'b0, 32'h0000_7000, 32'hAAAA_AAAA, 4'b1111);
        send(32'h0000_7001, 32'hBBBB_BBBB, ST_HALF, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000);
        req_valid = 1'b0;
        #1 reset = 1'b1;
        sb_q.delete();
        #1;
        check("rst1_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst1_empty", {31'd0, empty}, 32'd1);
        check("rst1_exc_ades", {31'd0, exc_ades}, 32'd0);
        check("rst1_exc_addr", exc_addr, 32'd0);
        check("rst1_mem_be", {28'd0, mem_be}, 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst1_no_write", {31'd0, mem_valid}, 32'd0);

        // Reset with the buffer full
        mem_ready = 1'b0;
        send(32'h0000_8000, 32'h1, ST_WORD, 1'b1, 1'b0, 32'h0000_8000, 32'h1, 4'b1111);
        send(32'h0000_8004, 32'h2, ST_WORD, 1'b1, 1'b0, 32'h0000_8004, 32'h2, 4'b1111);
        req_valid = 1'b0;
        check("rst2_full", {31'd0, req_ready}, 32'd0);
        #1 reset = 1'b1;
        sb_q.delete();
        #1;
        check("rst2_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst2_empty", {31'd0, empty}, 32'd1);
        check("rst2_mem_addr", mem_addr, 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst2_no_write", {31'd0, mem_valid}, 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
